// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, IF/ID payload and the bubble word.
package fetch_pkg;

   typedef enum logic [1:0] {BOOT, RUN, FAULT} fetch_state_e;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        valid;
   } ifid_t;

   // ADD XZR,XZR,XZR: architecturally a no-op, used for every pipeline bubble
   localparam logic [31:0] NOP_INSTR_DEF = 32'h8B1F03FF;

   // Word-aligned and the whole 4-byte word inside the ROM; 65-bit sum so pc+3 cannot wrap
   function automatic logic fetch_legal(input logic [63:0] pc, input logic [64:0] imem_limit);
      return (pc[1:0] == 2'b00) && (({1'b0, pc} + 65'd3) < imem_limit);
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register holding one ifid_t; flush wins over load, otherwise the contents hold.
module ifid_reg
   import fetch_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic  clk,
   input  logic  reset_n,
   input  logic  load,
   input  logic  flush,
   input  ifid_t d,
   output ifid_t q
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q.pc    <= '0;
         q.instr <= NOP_INSTR;
         q.valid <= 1'b0;
      end else if (flush) begin
         // pc is left as-is; a bubble's pc carries no meaning downstream
         q.instr <= NOP_INSTR;
         q.valid <= 1'b0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// LEGv8 fetch stage: PC register, next-PC selection and BOOT/RUN/FAULT control feeding IF/ID.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter int unsigned IMEM_SIZE = 1024,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         stall,
   input  logic         redirect_valid,
   input  logic [63:0]  redirect_target,
   output logic [63:0]  imem_addr,
   input  logic [31:0]  imem_instr,
   output logic [63:0]  ifid_pc,
   output logic [31:0]  ifid_instr,
   output logic         ifid_valid,
   output logic         fault,
   output fetch_state_e state_dbg
);

   localparam logic [64:0] IMEM_LIMIT = 65'(IMEM_SIZE);

   fetch_state_e state;
   logic [63:0]  pc;
   logic         pc_legal;
   logic         ifid_load;
   logic         ifid_flush;
   ifid_t        ifid_d;
   ifid_t        ifid_q;

   assign imem_addr = pc;
   assign state_dbg = state;
   assign pc_legal  = fetch_legal(pc, IMEM_LIMIT);

   // Illegal pc is tested before capture, so an X word from the ROM never enters IF/ID
   always_comb begin
      ifid_load  = 1'b0;
      ifid_flush = 1'b0;
      if (state == RUN) begin
         if (redirect_valid || !pc_legal) ifid_flush = 1'b1;
         else if (!stall)                 ifid_load  = 1'b1;
      end
   end

   assign ifid_d.pc    = pc;
   assign ifid_d.instr = imem_instr;
   assign ifid_d.valid = 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= BOOT;
         pc    <= RESET_PC;
         fault <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               if (redirect_valid) pc <= redirect_target;
               state <= RUN;
            end
            RUN: begin
               if (redirect_valid) begin
                  pc <= redirect_target;
               end else if (!pc_legal) begin
                  state <= FAULT;
                  fault <= 1'b1;
               end else if (!stall) begin
                  pc <= pc + 64'd4;
               end
            end
            FAULT: begin
               fault <= 1'b1;
            end
            default: begin
               state <= FAULT;
               fault <= 1'b1;
            end
         endcase
      end
   end

   ifid_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (ifid_load),
      .flush   (ifid_flush),
      .d       (ifid_d),
      .q       (ifid_q)
   );

   assign ifid_pc    = ifid_q.pc;
   assign ifid_instr = ifid_q.instr;
   assign ifid_valid = ifid_q.valid;

endmodule
